// File: rtl/n64_sdram_arbiter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// n64_sdram_arbiter_pkg : state and requester encodings for the SDRAM arbiter
// Revision: 1.0
// ---------------------------------------------------------------------------
package n64_sdram_arbiter_pkg;

   typedef enum logic [2:0] {
      ARB_IDLE     = 3'd0,
      ARB_N64      = 3'd1,
      ARB_CPU      = 3'd2,
      ARB_PREFETCH = 3'd3,
      ARB_HIT      = 3'd4
   } arb_state_e;

   typedef enum logic {
      REQ_N64 = 1'b0,
      REQ_CPU = 1'b1
   } req_id_e;

   localparam int WORD_BYTES = 2;

endpackage
`default_nettype wire

// File: rtl/n64_prefetch_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// n64_prefetch_buffer : single-entry tag/data/valid holder for the next word
// Revision: 1.0
// ---------------------------------------------------------------------------
module n64_prefetch_buffer
   import n64_sdram_arbiter_pkg::*;
#(
   parameter int ENABLE = 1,
   parameter int TAG_W  = 25
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             load_i,
   input  logic [TAG_W-1:0] load_tag_i,
   input  logic [15:0]      load_data_i,
   input  logic             inval_all_i,
   input  logic             inval_match_i,
   input  logic [TAG_W-1:0] match_tag_i,
   input  logic [TAG_W-1:0] lookup_tag_i,
   output logic             hit_o,
   output logic [TAG_W-1:0] tag_o,
   output logic [15:0]      data_o
);

   if (ENABLE != 0) begin : g_buffer
      logic             valid_q;
      logic             valid_d;
      logic [TAG_W-1:0] tag_q;
      logic [15:0]      data_q;

      always_comb begin
         valid_d = valid_q;
         if (load_i) begin
            valid_d = 1'b1;
         end else if (inval_all_i || (inval_match_i && (match_tag_i == tag_q))) begin
            valid_d = 1'b0;
         end
      end

      always_ff @(posedge clk_i) begin
         if (reset_i) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
         end else begin
            valid_q <= valid_d;
            if (load_i) begin
               tag_q  <= load_tag_i;
               data_q <= load_data_i;
            end
         end
      end

      assign hit_o  = valid_q && (lookup_tag_i == tag_q);
      assign tag_o  = tag_q;
      assign data_o = data_q;
   end else begin : g_no_buffer
      logic w_unused_inputs;
      assign w_unused_inputs = ^{clk_i, reset_i, load_i, load_tag_i, load_data_i,
                                 inval_all_i, inval_match_i, match_tag_i, lookup_tag_i};
      assign hit_o  = 1'b0;
      assign tag_o  = '0;
      assign data_o = '0;
   end

endmodule
`default_nettype wire

// File: rtl/n64_sdram_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// n64_sdram_arbiter : round-robin N64/CPU sharing of one SDRAM port, with prefetch
// Revision: 1.0
// ---------------------------------------------------------------------------
module n64_sdram_arbiter
   import n64_sdram_arbiter_pkg::*;
#(
   parameter int PREFETCH_ENABLE = 1,
   parameter int ADDR_W          = 26
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_n64_request,
   input  logic              i_n64_write,
   input  logic              i_n64_prefetch,
   input  logic [ADDR_W-1:0] i_n64_address,
   input  logic [15:0]       i_n64_wdata,
   output logic              o_n64_ack,
   output logic [15:0]       o_n64_rdata,
   input  logic              i_cpu_request,
   input  logic              i_cpu_write,
   input  logic [ADDR_W-1:0] i_cpu_address,
   input  logic [15:0]       i_cpu_wdata,
   output logic              o_cpu_ack,
   output logic [15:0]       o_cpu_rdata,
   output logic              o_mem_request,
   output logic              o_mem_write,
   output logic [ADDR_W-1:0] o_mem_address,
   output logic [15:0]       o_mem_wdata,
   input  logic              i_mem_ack,
   input  logic [15:0]       i_mem_rdata
);

   localparam int                c_tag_w     = ADDR_W - 1;
   localparam logic [ADDR_W-1:0] c_word_step = ADDR_W'(WORD_BYTES);

   arb_state_e        state_q, state_d;
   req_id_e           last_q, last_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_write_q, mem_write_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [15:0]       mem_wdata_q, mem_wdata_d;
   logic              n64_ack_q, n64_ack_d;
   logic [15:0]       n64_rdata_q, n64_rdata_d;
   logic              cpu_ack_q, cpu_ack_d;
   logic [15:0]       cpu_rdata_q, cpu_rdata_d;
   logic              hit_pf_q, hit_pf_d;

   logic               w_buf_load, w_inval_all, w_inval_match, w_buf_hit;
   logic [c_tag_w-1:0] w_buf_tag;
   logic [15:0]        w_buf_data;
   logic               w_n64_pend, w_cpu_pend, w_n64_wins, w_pf_ok;
   logic               w_unused_lsb;

   assign w_unused_lsb = i_n64_address[0] ^ i_cpu_address[0];

   // A requester still holding its request during its own ack cycle is not a new request.
   assign w_n64_pend = i_n64_request && !n64_ack_q;
   assign w_cpu_pend = i_cpu_request && !cpu_ack_q;
   assign w_n64_wins = w_n64_pend && (!w_cpu_pend || (last_q == REQ_CPU));
   assign w_pf_ok    = (PREFETCH_ENABLE != 0) && !mem_write_q && i_n64_prefetch && !i_cpu_request;

   n64_prefetch_buffer #(
      .ENABLE (PREFETCH_ENABLE),
      .TAG_W  (c_tag_w)
   ) u_buffer (
      .clk_i         (i_clk),
      .reset_i       (i_reset),
      .load_i        (w_buf_load),
      .load_tag_i    (mem_addr_q[ADDR_W-1:1]),
      .load_data_i   (i_mem_rdata),
      .inval_all_i   (w_inval_all),
      .inval_match_i (w_inval_match),
      .match_tag_i   (i_n64_address[ADDR_W-1:1]),
      .lookup_tag_i  (i_n64_address[ADDR_W-1:1]),
      .hit_o         (w_buf_hit),
      .tag_o         (w_buf_tag),
      .data_o        (w_buf_data)
   );

   always_comb begin
      state_d       = state_q;
      last_d        = last_q;
      mem_req_d     = mem_req_q;
      mem_write_d   = mem_write_q;
      mem_addr_d    = mem_addr_q;
      mem_wdata_d   = mem_wdata_q;
      n64_ack_d     = 1'b0;
      n64_rdata_d   = n64_rdata_q;
      cpu_ack_d     = 1'b0;
      cpu_rdata_d   = cpu_rdata_q;
      hit_pf_d      = hit_pf_q;
      w_buf_load    = 1'b0;
      w_inval_all   = 1'b0;
      w_inval_match = 1'b0;
      unique case (state_q)
         ARB_IDLE: begin
            if (w_n64_wins && !i_n64_write && w_buf_hit) begin
               state_d     = ARB_HIT;
               last_d      = REQ_N64;
               n64_ack_d   = 1'b1;
               n64_rdata_d = w_buf_data;
               w_inval_all = 1'b1;
               hit_pf_d    = i_n64_prefetch && (PREFETCH_ENABLE != 0);
            end else if (w_n64_wins) begin
               state_d       = ARB_N64;
               last_d        = REQ_N64;
               mem_req_d     = 1'b1;
               mem_write_d   = i_n64_write;
               mem_addr_d    = {i_n64_address[ADDR_W-1:1], 1'b0};
               mem_wdata_d   = i_n64_wdata;
               w_inval_match = i_n64_write;
               w_inval_all   = !i_n64_write;
            end else if (w_cpu_pend) begin
               state_d     = ARB_CPU;
               last_d      = REQ_CPU;
               mem_req_d   = 1'b1;
               mem_write_d = i_cpu_write;
               mem_addr_d  = {i_cpu_address[ADDR_W-1:1], 1'b0};
               mem_wdata_d = i_cpu_wdata;
               w_inval_all = 1'b1;
            end
         end
         ARB_N64, ARB_CPU: begin
            if (i_mem_ack) begin
               mem_req_d = 1'b0;
               if (state_q == ARB_N64) begin
                  n64_ack_d   = 1'b1;
                  n64_rdata_d = i_mem_rdata;
               end else begin
                  cpu_ack_d   = 1'b1;
                  cpu_rdata_d = i_mem_rdata;
               end
               // Prefetch request is raised one cycle later, keeping a gap after the ack.
               if ((state_q == ARB_N64) && w_pf_ok) begin
                  state_d     = ARB_PREFETCH;
                  mem_write_d = 1'b0;
                  mem_addr_d  = mem_addr_q + c_word_step;
               end else begin
                  state_d = ARB_IDLE;
               end
            end
         end
         ARB_HIT: begin
            hit_pf_d = 1'b0;
            if (hit_pf_q) begin
               state_d     = ARB_PREFETCH;
               mem_write_d = 1'b0;
               mem_addr_d  = {w_buf_tag, 1'b0} + c_word_step;
            end else begin
               state_d = ARB_IDLE;
            end
         end
         ARB_PREFETCH: begin
            if (!mem_req_q) begin
               mem_req_d = 1'b1;
            end else if (i_mem_ack) begin
               mem_req_d  = 1'b0;
               w_buf_load = 1'b1;
               state_d    = ARB_IDLE;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q     <= ARB_IDLE;
         last_q      <= REQ_CPU;
         mem_req_q   <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         n64_ack_q   <= 1'b0;
         n64_rdata_q <= '0;
         cpu_ack_q   <= 1'b0;
         cpu_rdata_q <= '0;
         hit_pf_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         mem_req_q   <= mem_req_d;
         mem_write_q <= mem_write_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         n64_ack_q   <= n64_ack_d;
         n64_rdata_q <= n64_rdata_d;
         cpu_ack_q   <= cpu_ack_d;
         cpu_rdata_q <= cpu_rdata_d;
         hit_pf_q    <= hit_pf_d;
      end
   end

   assign o_n64_ack     = n64_ack_q;
   assign o_n64_rdata   = n64_rdata_q;
   assign o_cpu_ack     = cpu_ack_q;
   assign o_cpu_rdata   = cpu_rdata_q;
   assign o_mem_request = mem_req_q;
   assign o_mem_write   = mem_write_q;
   assign o_mem_address = mem_addr_q;
   assign o_mem_wdata   = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_n64_sdram_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_n64_sdram_arbiter : scoreboard bench with SDRAM model and shadow memory
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_n64_sdram_arbiter;

   localparam int ADDR_W = 26;

   typedef struct { bit rd; logic [15:0] data; } sb_t;
   typedef struct { int addr; bit wr; } log_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              n64_req, n64_wr, n64_pf;
   logic [ADDR_W-1:0] n64_addr;
   logic [15:0]       n64_wdata;
   logic              o_n64_ack;
   logic [15:0]       o_n64_rdata;
   logic              cpu_req, cpu_wr;
   logic [ADDR_W-1:0] cpu_addr;
   logic [15:0]       cpu_wdata;
   logic              o_cpu_ack;
   logic [15:0]       o_cpu_rdata;
   logic              o_mem_request, o_mem_write;
   logic [ADDR_W-1:0] o_mem_address;
   logic [15:0]       o_mem_wdata;
   logic              i_mem_ack;
   logic [15:0]       i_mem_rdata;

   int checks   = 0;
   int failures = 0;

   sb_t         n64_exp[$];
   sb_t         cpu_exp[$];
   log_t        mem_log[$];
   logic [15:0] ref_mem[int];
   logic [15:0] sd_mem[int];
   int          lat_cfg  = 2;
   bit          lat_rand = 1'b0;

   always #5 clk = ~clk;

   n64_sdram_arbiter #(
      .PREFETCH_ENABLE (1),
      .ADDR_W          (ADDR_W)
   ) dut (
      .i_clk          (clk),
      .i_reset        (rst),
      .i_n64_request  (n64_req),
      .i_n64_write    (n64_wr),
      .i_n64_prefetch (n64_pf),
      .i_n64_address  (n64_addr),
      .i_n64_wdata    (n64_wdata),
      .o_n64_ack      (o_n64_ack),
      .o_n64_rdata    (o_n64_rdata),
      .i_cpu_request  (cpu_req),
      .i_cpu_write    (cpu_wr),
      .i_cpu_address  (cpu_addr),
      .i_cpu_wdata    (cpu_wdata),
      .o_cpu_ack      (o_cpu_ack),
      .o_cpu_rdata    (o_cpu_rdata),
      .o_mem_request  (o_mem_request),
      .o_mem_write    (o_mem_write),
      .o_mem_address  (o_mem_address),
      .o_mem_wdata    (o_mem_wdata),
      .i_mem_ack      (i_mem_ack),
      .i_mem_rdata    (i_mem_rdata)
   );

   function automatic logic [15:0] dflt(input int a);
      logic [31:0] av;
      av = a;
      return av[16:1] ^ 16'hC3A5;
   endfunction

   function automatic logic [15:0] ref_rd(input int a);
      return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
   endfunction

   function automatic logic [15:0] sd_rd(input int a);
      return sd_mem.exists(a) ? sd_mem[a] : dflt(a);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic expect_log(input string nm, input int addr, input bit wr);
      log_t l;
      if (mem_log.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL %s actual=no_sdram_access required=%h", nm, addr);
      end else begin
         l = mem_log.pop_front();
         chk(nm, 32'(l.addr), 32'(addr));
         chk({nm, "_wr"}, {31'h0, l.wr}, {31'h0, wr});
      end
   endtask

   task automatic wait_idle();
      int idle = 0;
      int n    = 0;
      while (idle < 4 && n < 500) begin
         @(posedge clk); #1;
         n++;
         if (o_mem_request) idle = 0;
         else idle++;
      end
      if (idle < 4) chk("idle_timeout", 32'(idle), 32'd4);
   endtask

   task automatic n64_xfer(input bit wr, input bit pf, input int addr, input logic [15:0] wd,
                           output int cyc);
      sb_t e;
      e.rd   = !wr;
      e.data = wr ? 16'h0 : ref_rd(addr);
      if (wr) ref_mem[addr] = wd;
      n64_exp.push_back(e);
      n64_wr = wr; n64_pf = pf; n64_addr = ADDR_W'(addr); n64_wdata = wd; n64_req = 1'b1;
      cyc = 0;
      do begin
         @(posedge clk); #1;
         cyc++;
      end while (!o_n64_ack && cyc < 200);
      if (!o_n64_ack) begin
         chk("n64_ack_timeout", 32'(cyc), 32'd0);
         void'(n64_exp.pop_back());
      end
      n64_req = 1'b0;
   endtask

   task automatic cpu_xfer(input bit wr, input int addr, input logic [15:0] wd, output int cyc);
      sb_t e;
      e.rd   = !wr;
      e.data = wr ? 16'h0 : ref_rd(addr);
      if (wr) ref_mem[addr] = wd;
      cpu_exp.push_back(e);
      cpu_wr = wr; cpu_addr = ADDR_W'(addr); cpu_wdata = wd; cpu_req = 1'b1;
      cyc = 0;
      do begin
         @(posedge clk); #1;
         cyc++;
      end while (!o_cpu_ack && cyc < 200);
      if (!o_cpu_ack) begin
         chk("cpu_ack_timeout", 32'(cyc), 32'd0);
         void'(cpu_exp.pop_back());
      end
      cpu_req = 1'b0;
   endtask

   // SDRAM model: one access at a time, ack after a configurable latency.
   initial begin
      int   cnt;
      int   cur;
      bit   serving;
      bit   prev_ack;
      log_t l;
      i_mem_ack = 1'b0; i_mem_rdata = 16'h0;
      cnt = 0; cur = 0; serving = 1'b0; prev_ack = 1'b0;
      forever begin
         @(posedge clk); #1;
         i_mem_ack = 1'b0;
         if (rst) begin
            serving  = 1'b0;
            prev_ack = 1'b0;
         end else begin
            if (prev_ack) chk("mem_req_after_ack", {31'h0, o_mem_request}, 32'h0);
            prev_ack = 1'b0;
            if (serving && !o_mem_request) serving = 1'b0;
            if (serving) chk("mem_addr_held", 32'(o_mem_address), 32'(cur));
            if (o_mem_request && !serving) begin
               serving = 1'b1;
               cur     = int'(o_mem_address);
               l.addr  = cur;
               l.wr    = o_mem_write;
               mem_log.push_back(l);
               cnt = lat_rand ? int'($urandom_range(0, 5)) : lat_cfg;
            end
            if (serving) begin
               if (cnt == 0) begin
                  i_mem_ack = 1'b1;
                  prev_ack  = 1'b1;
                  serving   = 1'b0;
                  if (o_mem_write) begin
                     sd_mem[cur] = o_mem_wdata;
                     i_mem_rdata = 16'($urandom);
                  end else begin
                     i_mem_rdata = sd_rd(cur);
                  end
               end else begin
                  cnt--;
               end
            end
         end
      end
   end

   // Monitor: pops the expected response whenever a requester is acked.
   initial begin
      bit  n64_prev;
      bit  cpu_prev;
      sb_t e;
      n64_prev = 1'b0; cpu_prev = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (rst) begin
            n64_prev = 1'b0;
            cpu_prev = 1'b0;
         end else begin
            if (n64_prev) chk("n64_ack_pulse", {31'h0, o_n64_ack}, 32'h0);
            if (cpu_prev) chk("cpu_ack_pulse", {31'h0, o_cpu_ack}, 32'h0);
            if (o_n64_ack) begin
               chk("n64_ack_expected", {31'h0, n64_exp.size() != 0}, 32'h1);
               if (n64_exp.size() != 0) begin
                  e = n64_exp.pop_front();
                  if (e.rd) chk("n64_rdata", 32'(o_n64_rdata), 32'(e.data));
               end
            end
            if (o_cpu_ack) begin
               chk("cpu_ack_expected", {31'h0, cpu_exp.size() != 0}, 32'h1);
               if (cpu_exp.size() != 0) begin
                  e = cpu_exp.pop_front();
                  if (e.rd) chk("cpu_rdata", 32'(o_cpu_rdata), 32'(e.data));
               end
            end
            n64_prev = o_n64_ack;
            cpu_prev = o_cpu_ack;
         end
      end
   end

   task automatic chk_outputs_zero(input string nm);
      chk({nm, "_n64_ack"},   {31'h0, o_n64_ack},     32'h0);
      chk({nm, "_n64_rdata"}, 32'(o_n64_rdata),       32'h0);
      chk({nm, "_cpu_ack"},   {31'h0, o_cpu_ack},     32'h0);
      chk({nm, "_cpu_rdata"}, 32'(o_cpu_rdata),       32'h0);
      chk({nm, "_mem_req"},   {31'h0, o_mem_request}, 32'h0);
      chk({nm, "_mem_write"}, {31'h0, o_mem_write},   32'h0);
      chk({nm, "_mem_addr"},  32'(o_mem_address),     32'h0);
      chk({nm, "_mem_wdata"}, 32'(o_mem_wdata),       32'h0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      int cyc_a;
      int cyc_b;
      int n;
      rst = 1'b1;
      n64_req = 1'b0; n64_wr = 1'b0; n64_pf = 1'b0; n64_addr = '0; n64_wdata = '0;
      cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      sd_mem[32'h1000000]  = 16'hBEEF; ref_mem[32'h1000000] = 16'hBEEF;
      sd_mem[32'h1000002]  = 16'h1234; ref_mem[32'h1000002] = 16'h1234;
      repeat (3) @(posedge clk);
      #1;
      chk_outputs_zero("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      // Simultaneous requests after reset: N64 first, then CPU beats N64's re-request.
      mem_log.delete();
      fork
         begin
            n64_xfer(1'b0, 1'b0, 32'h1000040, 16'h0, cyc_a);
            n64_xfer(1'b0, 1'b0, 32'h1000044, 16'h0, cyc_a);
         end
         cpu_xfer(1'b0, 32'h0200040, 16'h0, cyc_b);
      join
      wait_idle();
      expect_log("arb_first_n64", 32'h1000040, 1'b0);
      expect_log("arb_second_cpu", 32'h0200040, 1'b0);
      expect_log("arb_third_n64", 32'h1000044, 1'b0);

      // Miss with prefetch, SDRAM latency 4.
      lat_cfg = 4;
      mem_log.delete();
      n64_xfer(1'b0, 1'b1, 32'h1000000, 16'h0, cyc);
      chk("miss_latency", 32'(cyc), 32'd6);
      wait_idle();
      expect_log("miss_access", 32'h1000000, 1'b0);
      expect_log("prefetch_next", 32'h1000002, 1'b0);

      // Hit on the prefetched word.
      mem_log.delete();
      n64_xfer(1'b0, 1'b1, 32'h1000002, 16'h0, cyc);
      chk("hit_latency", 32'(cyc), 32'd1);
      wait_idle();
      expect_log("hit_prefetch_next", 32'h1000004, 1'b0);
      chk("hit_extra_access", 32'(mem_log.size()), 32'h0);

      // CPU write to the prefetched word forces a miss.
      lat_cfg = 2;
      n64_xfer(1'b0, 1'b1, 32'h000000E, 16'h0, cyc);
      wait_idle();
      cpu_xfer(1'b1, 32'h0000010, 16'hAAAA, cyc);
      wait_idle();
      mem_log.delete();
      n64_xfer(1'b0, 1'b0, 32'h0000010, 16'h0, cyc);
      wait_idle();
      expect_log("coh_cpu_write_miss", 32'h0000010, 1'b0);

      // Prefetch address wraps at the top of the space.
      mem_log.delete();
      n64_xfer(1'b0, 1'b1, 32'h3FFFFFE, 16'h0, cyc);
      wait_idle();
      expect_log("wrap_access", 32'h3FFFFFE, 1'b0);
      expect_log("wrap_prefetch", 32'h0000000, 1'b0);

      // Reset in the middle of an N64 access.
      n64_xfer(1'b0, 1'b1, 32'h1000020, 16'h0, cyc);
      wait_idle();
      lat_cfg = 20;
      n64_wr = 1'b0; n64_pf = 1'b0; n64_addr = ADDR_W'(32'h1000080); n64_req = 1'b1;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!o_mem_request && n < 50);
      chk("abort_access_started", {31'h0, o_mem_request}, 32'h1);
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk_outputs_zero("midreset");
      n64_req = 1'b0;
      rst = 1'b0;
      lat_cfg = 2;
      @(posedge clk); #1;
      mem_log.delete();
      n64_xfer(1'b0, 1'b0, 32'h1000022, 16'h0, cyc);
      wait_idle();
      expect_log("reset_buffer_invalid", 32'h1000022, 1'b0);

      // Random concurrent traffic in disjoint regions.
      lat_rand = 1'b1;
      fork
         begin
            int a;
            a = 0;
            for (int i = 0; i < 40; i++) begin
               int  c;
               int  gap;
               bit  wr;
               bit  pf;
               a   = ($urandom_range(0, 1) == 1) ? ((a + 2) % 16) : int'(2 * $urandom_range(0, 7));
               wr  = ($urandom_range(0, 2) == 0);
               pf  = $urandom_range(0, 1) == 1;
               gap = $urandom_range(0, 2);
               n64_xfer(wr, pf, 32'h1000100 + a, 16'($urandom), c);
               for (int g = 0; g < gap; g++) begin
                  @(posedge clk); #1;
               end
            end
         end
         begin
            for (int j = 0; j < 40; j++) begin
               int c;
               int gap;
               gap = $urandom_range(0, 3);
               cpu_xfer($urandom_range(0, 1) == 1, 32'h0200100 + int'(2 * $urandom_range(0, 7)),
                        16'($urandom), c);
               for (int g = 0; g < gap; g++) begin
                  @(posedge clk); #1;
               end
            end
         end
      join
      wait_idle();
      chk("n64_queue_drained", 32'(n64_exp.size()), 32'h0);
      chk("cpu_queue_drained", 32'(cpu_exp.size()), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/n64_sdram_arbiter.md
Name: n64_sdram_arbiter

Overview:
Shares the single SDRAM port between two requesters:
- the N64 PI side (requests whose decoded bank is SDRAM: ROM, DDIPL, SRAM);
- the CPU/USB DMA side.

The block sits between the N64 bus front-end and the SDRAM controller. It receives addresses that upstream decoding has already translated. For N64 reads flagged as prefetchable, it speculatively fetches the next 16-bit word into a one-entry buffer, so sequential PI bursts hit without an SDRAM round trip.

Parameters:
PREFETCH_ENABLE, 1, 1 = speculative next-word prefetch on N64 prefetchable reads; 0 = prefetch logic removed and buffer never valid
ADDR_W, 26, byte address width of the SDRAM space

Ports:
i_clk  in  1  system clock
i_reset  in  1  synchronous, active-high reset
i_n64_request  in  1  N64 access request, held until o_n64_ack
i_n64_write  in  1  1 = write, 0 = read; stable while request high
i_n64_prefetch  in  1  read may trigger next-word prefetch
i_n64_address  in  ADDR_W  translated byte address; bit 0 ignored
i_n64_wdata  in  16  write data
o_n64_ack  out  1  one-cycle completion pulse
o_n64_rdata  out  16  read data, valid with o_n64_ack
i_cpu_request  in  1  CPU access request, held until o_cpu_ack
i_cpu_write  in  1  1 = write
i_cpu_address  in  ADDR_W  byte address; bit 0 ignored
i_cpu_wdata  in  16  write data
o_cpu_ack  out  1  one-cycle completion pulse
o_cpu_rdata  out  16  read data, valid with o_cpu_ack
o_mem_request  out  1  SDRAM request, held until i_mem_ack
o_mem_write  out  1  SDRAM write
o_mem_address  out  ADDR_W  SDRAM byte address
o_mem_wdata  out  16  SDRAM write data
i_mem_ack  in  1  SDRAM done; i_mem_rdata valid this cycle on reads
i_mem_rdata  in  16  SDRAM read data

Behaviour:
- Reset (synchronous): all outputs 0, state IDLE, buffer invalid, last_grant = CPU. Any in-flight SDRAM access is abandoned; the SDRAM controller shares i_reset.
- States: IDLE, N64_ACCESS, CPU_ACCESS, PREFETCH, N64_HIT.
- IDLE, N64 buffer hit:
  - Condition: N64 read with buffer valid and address[ADDR_W-1:1] == tag.
  - Go to N64_HIT. Next cycle: o_n64_ack = 1, o_n64_rdata = buffer data, buffer invalidated.
  - If i_n64_prefetch, also issue PREFETCH of tag+2. Otherwise return to IDLE.
- IDLE, arbitration: round-robin on last_grant.
  - Both pending: the requester not granted last wins.
  - Single requester: it wins.
  - Grant registers the address/data/write fields onto o_mem_* and asserts o_mem_request in the next cycle.
- N64_ACCESS / CPU_ACCESS:
  - Hold o_mem_* until i_mem_ack.
  - Cycle after i_mem_ack: requester ack pulse; rdata registered from i_mem_rdata.
- Post-access transition:
  - N64 read with i_n64_prefetch (and PREFETCH_ENABLE) and no CPU request pending: go to PREFETCH with address = request address + 2.
  - Otherwise go to IDLE; the prefetch is dropped.
- PREFETCH:
  - Address wraps modulo 2^ADDR_W (0x3FFFFFE -> 0x0000000).
  - On i_mem_ack: buffer data = i_mem_rdata, tag = address[ADDR_W-1:1], valid = 1.
  - New requests wait until PREFETCH completes. Prefetch latency is not visible to requesters except as arbitration delay.
- Coherency:
  - Any write (N64 or CPU) whose word address equals the tag invalidates the buffer when the write is granted.
  - A CPU write arriving during PREFETCH to the prefetched address: the prefetch completes first, then the write grant invalidates.
  - Any granted CPU access invalidates the buffer. This is conservative and simplifies DMA coherency.
- Miss with valid buffer: the buffer is invalidated at grant.
- Request deasserted before ack: protocol violation; behaviour undefined. Requesters must hold request until ack.
- Requesters may re-assert the cycle after ack. Back-to-back acks to the same requester are at least 2 cycles apart.
- At most one o_mem_request outstanding. o_mem_request never asserts in the cycle after i_mem_ack.

Decomposition:
- constants.vh holds:
  - state encodings (ARB_IDLE, ARB_N64, ARB_CPU, ARB_PREFETCH, ARB_HIT);
  - requester IDs (REQ_N64, REQ_CPU).
- One natural sub-module: n64_prefetch_buffer. It holds the single-entry tag/data/valid, with load, invalidate-on-match, invalidate-all and hit compare.

Test Plan:
- N64 read 0x1000000 with prefetch, i_mem_ack 4 cycles later, data 0xBEEF -> o_n64_ack the cycle after, rdata 0xBEEF; o_mem_request then re-asserts with address 0x1000002.
- After the prefetch of 0x1000002 returns 0x1234, N64 reads 0x1000002 -> o_n64_ack 1 cycle after the request, rdata 0x1234, no mem access for it; prefetch of 0x1000004 issued.
- N64 and CPU both request in IDLE after reset (last_grant = CPU) -> N64 served first, CPU second; simultaneous again -> CPU first.
- Prefetch of 0x0000010 valid, CPU writes 0x0000010 = 0xAAAA, N64 reads 0x0000010 -> miss, SDRAM read issued, rdata 0xAAAA.
- N64 prefetchable read of 0x3FFFFFE -> prefetch address 0x0000000.
- i_reset pulsed during N64_ACCESS -> next cycle all outputs 0; buffer invalid; subsequent read goes to SDRAM.
